sevenseg_scan_decoder: RTL
==========================

// Module: sevenseg_scan_decoder
// PURPOSE
//   Receive-side counterpart of the binary-to-seven-segment encoder. Snoops a
//   multiplexed N-digit 7-segment drive bus (segments plus one-hot digit enables),
//   decodes each digit pattern back to BCD, and checks scan order. It publishes a
//   digit word only after STABLE_CNT consecutive identical frames.
//   Sits between the display driver and test/readback logic.
// PARAMETERS
//   NUM_DIGITS  4  digits per scan frame; digit 0 is scanned first
//   STABLE_CNT  3  identical consecutive frames required before publishing (>=1)
// PORTS
//   clk          in   1             rising-edge clock
//   rst          in   1             synchronous, active-high reset
//   seg_in       in   7             segment levels, active-high, [6]=a .. [0]=g
//   dig_en       in   NUM_DIGITS    digit enables, active-high, one-hot when driven
//   sample       in   1             seg_in/dig_en are valid and settled this cycle
//   value_out    out  4*NUM_DIGITS  published BCD word; digit i at [4i+3:4i]
//   invalid_out  out  NUM_DIGITS    per-digit flag: published digit had an illegal pattern
//   frame_valid  out  1             1-cycle pulse when value_out updates
//   frame_err    out  1             1-cycle pulse on a scan-order or one-hot violation
// BEHAVIOUR
//   - Reset values:
//     - value_out = {NUM_DIGITS{4'hF}}; invalid_out = 0; frame_valid = 0; frame_err = 0.
//     - FSM = IDLE; stable counter = 0; shadow and previous-frame registers = all 4'hF.
//   - Stage 1: seg_in, dig_en and sample are registered unconditionally.
//   - Stage 2: the decode and FSM act on the stage-1 copy. All outputs are registered.
//     - Latency from sample presented to frame_valid/frame_err high is 2 clocks.
//   - Decode table (seg -> code):
//     - 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9.
//     - 00 (blank) -> F.
//     - Any other pattern -> E, and the digit's invalid bit is set.
//   - A sample with dig_en == 0 is a blanking interval: ignored, no error, no state change.
//   - A sample with dig_en not one-hot (two or more bits set): frame_err, FSM -> IDLE,
//     partial frame discarded.
//   - FSM states: IDLE, SCAN(idx).
//     - IDLE: the first sample of digit 0 is captured into shadow[0] -> SCAN(0).
//       Any other digit is ignored silently (this is resynchronisation, not an error).
//     - SCAN(idx): a sample of digit idx is a repeat and is ignored; the first capture wins.
//       A sample of digit idx+1 is captured -> SCAN(idx+1).
//       Any other digit: frame_err, -> IDLE. A digit 0 sample in this case is NOT
//       re-captured in the same cycle.
//     - Capture of digit NUM_DIGITS-1 completes the frame: perform the frame compare
//       below, then FSM -> IDLE.
//   - Frame compare, done in the completing cycle:
//     - If shadow == prev: stable counter increments, saturating at STABLE_CNT.
//       Otherwise the counter is set to 1.
//     - prev <= shadow.
//     - When the counter reaches STABLE_CNT in this cycle (a transition, not saturation)
//       and shadow != value_out: update value_out and invalid_out and pulse frame_valid.
//       This covers STABLE_CNT=1, where every changed frame publishes.
//     - Further identical frames never re-pulse frame_valid.
//   - frame_err and frame_valid are never high in the same cycle.
//   - rst asserted mid-scan: all state returns to reset values on that edge.
//     Stage-1 contents are cleared to zero.
// STRUCTURE
//   - Shared package sevenseg_pkg holds:
//     - the ten SEG_x pattern constants (shared with the encoder);
//     - CODE_BLANK = 4'hF and CODE_INV = 4'hE;
//     - the scan-FSM state typedef.
//   - One sub-module, sevenseg_pattern_decode: combinational, 7-bit pattern in,
//     4-bit code plus invalid flag out. The FSM, counters and registers stay in the top level.
// TESTING
//   1. Reset, then scan digits 0..3 with patterns 30, 6D, 79, 33 three times
//      (STABLE_CNT=3) -> a single frame_valid pulse 2 clocks after the third digit-3
//      sample; value_out = 16'h4321; invalid_out = 0.
//   2. Same frame twice, then one frame with digit 2 = 5B, then three frames with the
//      original values -> no frame_valid before the final 3-frame run; value_out = 16'h4321.
//   3. Digit order 0, 2 -> frame_err 1-cycle pulse; the following clean scan 0..3
//      is accepted normally.
//   4. dig_en = 4'b0011 with sample -> frame_err. Zero-enable samples interleaved in a
//      scan -> no error, frame still completes.
//   5. Digit 1 pattern 0x01 (g only), three stable frames -> value_out[7:4] = E and
//      invalid_out = 4'b0010. Pattern 0x00 -> code F, invalid bit 0.
//   6. rst asserted after digit 1 of a scan -> outputs at reset values. The next three
//      full scans are required before frame_valid fires.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared seven-segment constants and scan FSM state type
//
// Purpose : segment patterns (shared with the encoder side), decode codes
//           for blank and illegal patterns, and the scan-FSM state typedef.
// Ports   : none (package).
package sevenseg_pkg;

    // Segment order is [6]=a .. [0]=g, active-high.
    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_INV   = 4'hE;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

endpackage

// File: rtl/sevenseg_pattern_decode.sv
// rtl/sevenseg_pattern_decode.sv - combinational 7-segment pattern to BCD decoder
//
// Purpose : map one 7-bit segment pattern back to its BCD code.
// Ports   : i_seg     [6:0] segment pattern, [6]=a .. [0]=g
//           o_code    [3:0] 0..9, CODE_BLANK for all-off, CODE_INV otherwise
//           o_invalid       high when the pattern is neither a digit nor blank
module sevenseg_pattern_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_code,
    output logic       o_invalid
);

    always_comb begin
        o_code    = CODE_INV;
        o_invalid = 1'b0;
        case (i_seg)
            SEG_0:     o_code = 4'd0;
            SEG_1:     o_code = 4'd1;
            SEG_2:     o_code = 4'd2;
            SEG_3:     o_code = 4'd3;
            SEG_4:     o_code = 4'd4;
            SEG_5:     o_code = 4'd5;
            SEG_6:     o_code = 4'd6;
            SEG_7:     o_code = 4'd7;
            SEG_8:     o_code = 4'd8;
            SEG_9:     o_code = 4'd9;
            SEG_BLANK: o_code = CODE_BLANK;
            default: begin
                o_code    = CODE_INV;
                o_invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// rtl/sevenseg_scan_decoder.sv - snoops a multiplexed 7-seg bus and publishes stable BCD frames
//
// Purpose : register the scan bus, decode each digit, enforce scan order and
//           publish a digit word after STABLE_CNT identical consecutive frames.
// Ports   : clk, rst           clock, synchronous active-high reset
//           seg_in  [6:0]      segment levels, [6]=a .. [0]=g
//           dig_en  [N-1:0]    one-hot digit enables
//           sample             bus valid this cycle
//           value_out [4N-1:0] published BCD word, digit i at [4i+3:4i]
//           invalid_out [N-1:0] published digit had an illegal pattern
//           frame_valid        1-cycle pulse when value_out updates
//           frame_err          1-cycle pulse on scan-order / one-hot violation
module sevenseg_scan_decoder
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    input  logic                    sample,
    output logic [4*NUM_DIGITS-1:0] value_out,
    output logic [NUM_DIGITS-1:0]   invalid_out,
    output logic                    frame_valid,
    output logic                    frame_err
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(STABLE_CNT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_STABLE = CNT_W'(STABLE_CNT);

    // Stage 1: raw bus copy
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_dig;
    logic                  r_sample;

    // Stage 2 state
    scan_state_t             r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [NUM_DIGITS-1:0]   r_shadow_inv;
    logic [4*NUM_DIGITS-1:0] r_prev;
    logic [CNT_W-1:0]        r_cnt;

    logic [3:0]              w_code;
    logic                    w_inv;
    logic [IDX_W-1:0]        w_dig_idx;
    logic [IDX_W-1:0]        w_next_idx;
    logic                    w_any;
    logic                    w_multi;
    logic                    w_capture;
    logic                    w_err;
    logic                    w_last;
    logic [4*NUM_DIGITS-1:0] w_frame;
    logic [NUM_DIGITS-1:0]   w_frame_inv;
    logic                    w_eq;
    logic [CNT_W-1:0]        w_cnt_next;
    logic                    w_publish;

    sevenseg_pattern_decode u_decode (
        .i_seg     (r_seg),
        .o_code    (w_code),
        .o_invalid (w_inv)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg    <= '0;
            r_dig    <= '0;
            r_sample <= 1'b0;
        end else begin
            r_seg    <= seg_in;
            r_dig    <= dig_en;
            r_sample <= sample;
        end
    end

    always_comb begin
        w_dig_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_dig[i]) w_dig_idx = IDX_W'(i);
        end
    end

    assign w_any      = |r_dig;
    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign w_multi    = |(r_dig & (r_dig - 1'b1));
    assign w_next_idx = r_idx + 1'b1;
    assign w_last     = (w_dig_idx == LAST_IDX);

    always_comb begin
        w_capture = 1'b0;
        w_err     = 1'b0;
        if (r_sample && w_any) begin
            if (w_multi) begin
                w_err = 1'b1;
            end else if (r_state == ST_IDLE) begin
                // Only digit 0 starts a frame; anything else is resync, not an error.
                w_capture = (w_dig_idx == '0);
            end else if (w_dig_idx == r_idx) begin
                w_capture = 1'b0;
            end else if (w_dig_idx == w_next_idx) begin
                w_capture = 1'b1;
            end else begin
                w_err = 1'b1;
            end
        end
    end

    // Frame as it will look after this cycle's capture, so the completing
    // digit takes part in the compare in the same cycle.
    always_comb begin
        w_frame                    = r_shadow;
        w_frame_inv                = r_shadow_inv;
        w_frame[4*w_dig_idx +: 4]  = w_code;
        w_frame_inv[w_dig_idx]     = w_inv;
    end

    assign w_eq       = (w_frame == r_prev);
    assign w_cnt_next = !w_eq                  ? CNT_W'(1) :
                        (r_cnt == CNT_STABLE)  ? r_cnt     : r_cnt + 1'b1;
    // Publish only on the transition into STABLE_CNT; a saturated count of
    // identical frames must not re-pulse.
    assign w_publish  = (w_cnt_next == CNT_STABLE) &&
                        !(w_eq && (r_cnt == CNT_STABLE)) &&
                        (w_frame != value_out);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_shadow     <= {NUM_DIGITS{CODE_BLANK}};
            r_shadow_inv <= '0;
            r_prev       <= {NUM_DIGITS{CODE_BLANK}};
            r_cnt        <= '0;
            value_out    <= {NUM_DIGITS{CODE_BLANK}};
            invalid_out  <= '0;
            frame_valid  <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= w_err;
            if (w_err) begin
                r_state <= ST_IDLE;
            end else if (w_capture) begin
                r_shadow     <= w_frame;
                r_shadow_inv <= w_frame_inv;
                if (w_last) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= w_cnt_next;
                    r_prev  <= w_frame;
                    if (w_publish) begin
                        value_out   <= w_frame;
                        invalid_out <= w_frame_inv;
                        frame_valid <= 1'b1;
                    end
                end else begin
                    r_state <= ST_SCAN;
                    r_idx   <= w_dig_idx;
                end
            end
        end
    end

endmodule
